// File: rtl/conv_pkg.sv
// Shared constants and types for the 8b<->32b converter pair on the link
// return path. Both directions import this so their widths cannot drift apart.
package conv_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int IDX_W          = 2;

    localparam logic [BYTE_W-1:0] IDLE_BYTE_DEF = 8'h00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/conv_32b_8b_if.sv
// Word-in / byte-out bundle of the 32b->8b converter, plus read-only
// visibility of the serializer state for checkers.
interface conv_32b_8b_if;
    import conv_pkg::*;

    // Handshake: a word transfers at a rising edge where valid_in and ready_out
    // are both 1; data_in is ignored otherwise. ready_out is a registered
    // output and never depends on valid_in in the same cycle. The byte side
    // has no back-pressure: every byte with valid_out=1 is consumed.
    logic [WORD_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic [BYTE_W-1:0] data_out;
    logic              valid_out;
    state_t            dbg_state;
    logic [IDX_W-1:0]  dbg_idx;

    modport slave (
        input  data_in, valid_in,
        output ready_out, data_out, valid_out, dbg_state, dbg_idx
    );

    modport master (
        output data_in, valid_in,
        input  ready_out, data_out, valid_out, dbg_state, dbg_idx
    );

endinterface

// File: rtl/word_hold_reg.sv
// Single-entry word buffer: holds the next word while the current one is
// being serialized. Load and unload never coincide in the parent.
module word_hold_reg
    import conv_pkg::*;
(
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o
);

    logic [WORD_W-1:0] data_q;
    logic              valid_q;

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/conv_32b_8b.sv
// 32-bit to 8-bit width converter: one word in, four registered bytes out,
// with a one-word holding register so a continuous stream has no idle cycles.
module conv_32b_8b
    import conv_pkg::*;
#(
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
    input  logic          clk_4f,
    input  logic          reset_L,
    conv_32b_8b_if.slave  bus
);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;
    logic [BYTE_W-1:0]     dout_q, dout_d;
    logic                  vout_q, vout_d;

    logic                  hold_v;
    logic [WORD_W-1:0]     hold_data;
    logic                  hold_load, hold_unload;
    logic                  load_en;
    logic [WORD_W-1:0]     load_word;
    logic                  accept;

    // ready comes straight from the hold flag flop, so no path from valid_in.
    assign bus.ready_out = ~hold_v;
    assign accept        = bus.valid_in & ~hold_v;

    word_hold_reg u_hold (
        .clk_4f   (clk_4f),
        .reset_L  (reset_L),
        .load_i   (hold_load),
        .unload_i (hold_unload),
        .data_i   (bus.data_in),
        .data_o   (hold_data),
        .valid_o  (hold_v)
    );

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= IDLE_BYTE;
            vout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        vout_d      = vout_q;
        hold_load   = 1'b0;
        hold_unload = 1'b0;
        load_en     = 1'b0;
        load_word   = bus.data_in;

        case (state_q)
            ST_IDLE: begin
                load_en = accept;
            end
            ST_SEND: begin
                if (idx_q != IDX_W'(BYTES_PER_WORD - 1)) begin
                    idx_d     = idx_q + 1'b1;
                    hold_load = accept;
                    if (MSB_FIRST) begin
                        dout_d  = shift_q[WORD_W-BYTE_W-1 -: BYTE_W];
                        shift_d = {shift_q[WORD_W-2*BYTE_W-1:0], {BYTE_W{1'b0}}};
                    end else begin
                        dout_d  = shift_q[BYTE_W-1:0];
                        shift_d = {{BYTE_W{1'b0}}, shift_q[WORD_W-BYTE_W-1:BYTE_W]};
                    end
                end else if (hold_v) begin
                    // The held word has priority; accept is 0 here since ready is low.
                    load_en     = 1'b1;
                    load_word   = hold_data;
                    hold_unload = 1'b1;
                end else if (accept) begin
                    load_en = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    vout_d  = 1'b0;
                    dout_d  = IDLE_BYTE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_en) begin
            state_d = ST_SEND;
            idx_d   = '0;
            vout_d  = 1'b1;
            if (MSB_FIRST) begin
                dout_d  = load_word[WORD_W-1 -: BYTE_W];
                shift_d = load_word[WORD_W-BYTE_W-1:0];
            end else begin
                dout_d  = load_word[BYTE_W-1:0];
                shift_d = load_word[WORD_W-1:BYTE_W];
            end
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.valid_out = vout_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_idx   = idx_q;

endmodule

// File: tb/tb_conv_32b_8b.sv
// Directed bench for conv_32b_8b: cycle-exact byte checks plus an in-order
// byte scoreboard on the MSB-first instance; one LSB-first instance.
module tb_conv_32b_8b;
    import conv_pkg::*;

    logic clk_4f;
    logic reset_L;

    conv_32b_8b_if bus_msb ();
    conv_32b_8b_if bus_lsb ();

    conv_32b_8b #(.MSB_FIRST(1'b1), .IDLE_BYTE(8'h00)) dut_msb (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .bus     (bus_msb.slave)
    );

    conv_32b_8b #(.MSB_FIRST(1'b0), .IDLE_BYTE(8'h00)) dut_lsb (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .bus     (bus_lsb.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    bit         sb_en = 1'b0;

    task automatic push_exp(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    always @(negedge clk_4f) begin
        if (sb_en && bus_msb.valid_out === 1'b1) begin
            if (exp_q.size() == 0) check("sb_extra_byte", {24'h0, bus_msb.data_out}, 32'hxxxx_xxxx);
            else                   check("sb_byte", {24'h0, bus_msb.data_out}, {24'h0, exp_q.pop_front()});
        end
    end

    // ---------------- drivers ----------------
    // All drivers run at posedge+#1 and return at posedge+#1.
    task automatic push_word(input logic [31:0] w);
        bit done = 1'b0;
        bus_msb.data_in  = w;
        bus_msb.valid_in = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            if (bus_msb.ready_out === 1'b1) begin
                push_exp(w);
                done = 1'b1;
            end
            @(posedge clk_4f); #1;
        end
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
            @(posedge clk_4f); #1;
        end
        @(posedge clk_4f); #1;
        @(posedge clk_4f); #1;
        check({tag, "_drained"}, exp_q.size(), 32'd0);
        check({tag, "_idle"}, {bus_msb.ready_out, bus_msb.valid_out, bus_msb.data_out}, {1'b1, 1'b0, 8'h00});
    endtask

    function automatic logic [31:0] outs_msb();
        return {22'h0, bus_msb.ready_out, bus_msb.valid_out, bus_msb.data_out};
    endfunction

    // ---------------- stimulus ----------------
    logic [7:0] t2_data[5]  = '{8'hFF, 8'hDD, 8'hAA, 8'h03, 8'h00};
    logic       t2_valid[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] t3_data[13] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hDD, 8'hDD, 8'hDD, 8'hDD,
                                8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
    logic       t3_ready[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] t6_data[5]  = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    logic [31:0] t4_words[4] = '{32'h01020304, 32'hA5A55A5A, 32'hDEADBEEF, 32'h0BADF00D};

    initial begin
        reset_L          = 1'b0;
        bus_msb.valid_in = 1'b0;
        bus_msb.data_in  = 32'hAAAAAAAA;
        bus_lsb.valid_in = 1'b0;
        bus_lsb.data_in  = 32'h0;
        #1;
        check("reset_outs", outs_msb(), {22'h0, 1'b1, 1'b0, 8'h00});
        check("reset_state", {31'h0, bus_msb.dbg_state}, {31'h0, ST_IDLE});

        repeat (2) @(posedge clk_4f);
        @(negedge clk_4f) reset_L = 1'b1;
        @(posedge clk_4f); #1;
        sb_en = 1'b1;

        // idle with garbage data and valid_in=0
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_4f); #1;
            check($sformatf("idle_c%0d", i), outs_msb(), {22'h0, 1'b1, 1'b0, 8'h00});
        end

        // single word, cycle exact
        bus_msb.data_in  = 32'hFFDDAA03;
        bus_msb.valid_in = 1'b1;
        push_exp(32'hFFDDAA03);
        for (int e = 0; e < 5; e++) begin
            @(posedge clk_4f); #1;
            bus_msb.valid_in = 1'b0;
            bus_msb.data_in  = 32'hAAAAAAAA;
            check($sformatf("single_e%0d", e), {23'h0, bus_msb.valid_out, bus_msb.data_out},
                  {23'h0, t2_valid[e], t2_data[e]});
        end

        // back-to-back with valid held high; third word stalls behind the hold register
        push_exp(32'hFFFFFFFF);
        push_exp(32'hDDDDDDDD);
        push_exp(32'h00000003);
        for (int e = 0; e < 13; e++) begin
            bus_msb.valid_in = (e <= 5);
            bus_msb.data_in  = (e == 0) ? 32'hFFFFFFFF : (e == 1) ? 32'hDDDDDDDD : 32'h00000003;
            @(posedge clk_4f); #1;
            check($sformatf("b2b_e%0d", e), outs_msb(),
                  {22'h0, t3_ready[e], (e < 12), t3_data[e]});
        end
        bus_msb.valid_in = 1'b0;
        check("b2b_sb_empty", exp_q.size(), 32'd0);

        // stream through the handshake driver, scoreboard only
        for (int i = 0; i < 4; i++) push_word(t4_words[i]);
        bus_msb.valid_in = 1'b0;
        drain("stream");

        // asynchronous reset mid-word with a word held
        push_word(32'h11223344);
        push_word(32'h55667788);
        bus_msb.valid_in = 1'b0;
        check("pre_reset_byte1", outs_msb(), {22'h0, 1'b0, 1'b1, 8'h22});
        #2;
        reset_L = 1'b0;
        #1;
        check("async_reset_outs", outs_msb(), {22'h0, 1'b1, 1'b0, 8'h00});
        exp_q.delete();
        @(posedge clk_4f); #1;
        check("reset_hold_outs", outs_msb(), {22'h0, 1'b1, 1'b0, 8'h00});
        @(negedge clk_4f) reset_L = 1'b1;
        @(posedge clk_4f); #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_4f); #1;
            check($sformatf("post_reset_idle%0d", i), outs_msb(), {22'h0, 1'b1, 1'b0, 8'h00});
        end
        push_word(32'hCAFE0123);
        bus_msb.valid_in = 1'b0;
        drain("post_reset");

        // LSB-first instance
        bus_lsb.data_in  = 32'h11223344;
        bus_lsb.valid_in = 1'b1;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk_4f); #1;
            bus_lsb.valid_in = 1'b0;
            check($sformatf("lsb_e%0d", e), {23'h0, bus_lsb.valid_out, bus_lsb.data_out},
                  {23'h0, (e < 4), t6_data[e]});
        end

        sb_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_32b_8b.md
Name: conv_32b_8b

Overview:
Width converter for the return path of the 8b/32b link. It accepts 32-bit words over a valid/ready handshake and emits them as four consecutive 8-bit bytes, MSB byte first, with valid_out asserted, all in the clk_4f domain. A one-word holding register lets the next word be accepted while the current word is still being serialized, so a continuous stream runs with no idle cycles. The 8-bit output format, idle behaviour and byte order are exactly what the existing 8b->32b converter consumes, so the two blocks can be connected back-to-back for loopback.

Parameters:
MSB_FIRST, 1, 1: emit data_in[31:24] first; 0: emit data_in[7:0] first.
IDLE_BYTE, 8'h00, value driven on data_out whenever valid_out=0.

Ports:
clk_4f  input  1  single clock; byte-rate clock; all state updates on its rising edge.
reset_L  input  1  asynchronous, active-low reset.
data_in  input  32  word to serialize; sampled only on acceptance.
valid_in  input  1  data_in holds a valid word.
ready_out  output  1  block can accept a word this cycle.
data_out  output  8  current output byte; registered.
valid_out  output  1  data_out holds a valid byte; registered.

Behaviour:
- Reset (reset_L=0, asynchronous): valid_out=0, data_out=IDLE_BYTE, ready_out=1, byte counter=0, holding register empty. Any partially sent word and any buffered word are discarded; there is no resumption after reset.
- Acceptance: a word is accepted at a rising edge where valid_in=1 and ready_out=1. When valid_in=0, data_in is ignored whatever its value.
- ready_out is 1 exactly when the holding register is empty. It is driven from a flop with no combinational path from valid_in.
- State: IDLE or SEND, plus a 2-bit byte index (0..3), a 24-bit remainder shift register, and a holding register with a valid flag (hold_v).
- IDLE, accept at edge k: at edge k, data_out = byte0 and valid_out = 1; go to SEND with index 0. Latency is one edge.
- SEND: each edge advances the index and drives the next byte. Bytes 1, 2 and 3 appear after edges k+1, k+2 and k+3.
- Accept while in SEND: the word goes into the holding register, hold_v=1, and ready_out=0.
- End of word, at the edge after byte3 is driven (index 3):
  - hold_v=1: load the held word, drive its byte0, clear hold_v (ready_out=1 after this edge).
  - hold_v=0 and an accept at this edge: load data_in directly and drive its byte0.
  - Neither: go to IDLE; valid_out=0, data_out=IDLE_BYTE.
- Throughput: 1 word per 4 cycles with no gaps when the source keeps up. Worst-case buffering is the word being sent plus one held word.
- Simultaneous events: if hold_v=1, ready_out=0, so only one word can ever be loaded at the end-of-word edge. If the holding register drains at the same edge a new word is presented, that new word is not accepted, because ready_out was 0 at that edge; it is accepted on the next edge.
- Byte order: with MSB_FIRST=1 the bytes are [31:24], [23:16], [15:8], [7:0]. With MSB_FIRST=0 the order is reversed.
- data_out never changes mid-cycle. It does not toggle while valid_out=0.

Decomposition:
- Shared package conv_pkg: BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4, IDX_W=2, default IDLE_BYTE. The same package is used by the 8b->32b converter.
- One sub-module: word_hold_reg, a 32-bit single-entry buffer with load/unload and a valid flag, using the same clock and reset.
- Byte selection and the shift logic stay in the top module.

Test Plan:
- Reset then idle, valid_in=0, data_in=32'hAAAAAAAA for 8 cycles -> valid_out=0, data_out=8'h00, ready_out=1 throughout.
- Single word 32'hFFDDAA03, accepted at edge k -> after edges k..k+3 data_out = FF, DD, AA, 03 with valid_out=1; after edge k+4, valid_out=0 and data_out=00.
- Back-to-back words 32'hFFFFFFFF, 32'hDDDDDDDD, 32'h00000003 with valid_in held high -> 12 contiguous valid bytes FF×4, DD×4, 00, 00, 00, 03 with no gap. ready_out drops after the second accept and rises after the held word is loaded.
- Holding full and a third word presented -> ready_out=0 stalls it until the end-of-word edge; no byte is lost or duplicated, checked with a scoreboard against input order.
- reset_L pulsed low mid-word, after byte1 of 32'h11223344, with 32'h55667788 held -> outputs clear immediately (asynchronously); after release only newly accepted words appear.
- MSB_FIRST=0 with 32'h11223344 -> data_out = 44, 33, 22, 11.
